// File: rtl/alu_reservation_station.sv
// ALU reservation station: collapsing-queue scheduler that holds dispatched
// ALU micro-ops until both source operands are ready, then issues the oldest
// ready one into a single registered issue slot toward the ALU.
// Optional feature macro: RS_WAKEUP_BYPASS_EN -- when defined, a wakeup
// broadcast on the current edge already counts toward issue eligibility.

package alu_rs_pkg;
  localparam int TAG_W = 6;

  typedef struct packed {
    logic [3:0]       opcode;
    logic [TAG_W-1:0] dest;
    logic [TAG_W-1:0] operand_a;
    logic [TAG_W-1:0] operand_b;
    logic [15:0]      imm;
  } micro_op_t;
endpackage

module alu_reservation_station
  import alu_rs_pkg::*;
#(
  parameter int NUM_PHYSICAL_REGS = 64,
  parameter int RS_DEPTH          = 8,
  localparam int PW = $clog2(NUM_PHYSICAL_REGS),
  localparam int IW = $clog2(RS_DEPTH),
  localparam int CW = IW + 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_uop_p,
  input  micro_op_t            i_uop,
  input  logic [1:0]           i_opr_rdy,
  output logic                 o_stall,
  input  logic [1:0]           i_wb_we,
  input  logic [1:0][PW-1:0]   i_wb_trgt,
  output logic                 o_uop_p,
  output micro_op_t            o_uop,
  input  logic                 i_alu_stall,
  input  logic                 i_flush,
  output logic [CW-1:0]        o_count
);

  // Entry storage; valid entries always occupy indices 0..count-1.
  logic [RS_DEPTH-1:0] valid_q, valid_d;
  logic [RS_DEPTH-1:0] rdy_a_q, rdy_a_d;
  logic [RS_DEPTH-1:0] rdy_b_q, rdy_b_d;
  micro_op_t           uop_q [RS_DEPTH];
  micro_op_t           uop_d [RS_DEPTH];

  // Issue register and occupancy counter.
  logic                out_valid_q, out_valid_d;
  micro_op_t           out_uop_q, out_uop_d;
  logic [CW-1:0]       count_q, count_d;

  // Wakeup matches and eligibility per entry.
  logic [RS_DEPTH-1:0] hit_a, hit_b, elig;

  // Per-slot view of the queue after the optional collapse of this edge.
  logic [RS_DEPTH-1:0] kept_valid, kept_ra, kept_rb;
  micro_op_t           kept_uop [RS_DEPTH];

  logic [IW-1:0]       sel_idx;
  logic                sel_found;
  logic                can_sel;
  logic                issue;
  logic                accept;
  logic [CW-1:0]       wr_idx;
  logic                disp_rdy_a, disp_rdy_b;

  // True when either write port broadcasts the given source tag.
  function automatic logic tag_hit(input logic [1:0]         we,
                                   input logic [1:0][PW-1:0] trgt,
                                   input logic [TAG_W-1:0]   tag);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (we[k] && (trgt[k] == PW'(tag))) hit = 1'b1;
    end
    return hit;
  endfunction

  // Wakeup comparators and readiness per held entry.
  for (genvar gi = 0; gi < RS_DEPTH; gi++) begin : g_wake
    assign hit_a[gi] = tag_hit(i_wb_we, i_wb_trgt, uop_q[gi].operand_a);
    assign hit_b[gi] = tag_hit(i_wb_we, i_wb_trgt, uop_q[gi].operand_b);
`ifdef RS_WAKEUP_BYPASS_EN
    // A broadcast on this edge already satisfies the operand.
    assign elig[gi] = valid_q[gi] && (rdy_a_q[gi] || hit_a[gi])
                                  && (rdy_b_q[gi] || hit_b[gi]);
`else
    // Only ready bits captured on earlier edges count.
    assign elig[gi] = valid_q[gi] && rdy_a_q[gi] && rdy_b_q[gi];
`endif
  end

  // Oldest-first pick: lowest index eligible entry wins.
  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (elig[i]) begin
        sel_idx   = IW'(i);
        sel_found = 1'b1;
      end
    end
  end

  // Full means occupancy before this edge's issue; an issue does not free a
  // slot for a dispatch in the same cycle.
  assign o_stall = (count_q == CW'(RS_DEPTH));
  assign can_sel = !out_valid_q || !i_alu_stall;
  assign issue   = can_sel && sel_found;
  assign accept  = i_uop_p && !o_stall;
  // First free slot once the issued entry (if any) has been squeezed out.
  assign wr_idx  = count_q - CW'(issue);

  assign disp_rdy_a = i_opr_rdy[0] | tag_hit(i_wb_we, i_wb_trgt, i_uop.operand_a);
  assign disp_rdy_b = i_opr_rdy[1] | tag_hit(i_wb_we, i_wb_trgt, i_uop.operand_b);

  // Collapse: every slot at or above the issued index takes its younger
  // neighbour; wakeups are folded into the ready bits as they move.
  for (genvar gi = 0; gi < RS_DEPTH; gi++) begin : g_shift
    logic shift_in;
    assign shift_in = issue && (IW'(gi) >= sel_idx);
    if (gi == RS_DEPTH - 1) begin : g_top
      assign kept_valid[gi] = valid_q[gi] && !shift_in;
      assign kept_uop[gi]   = uop_q[gi];
      assign kept_ra[gi]    = rdy_a_q[gi] | hit_a[gi];
      assign kept_rb[gi]    = rdy_b_q[gi] | hit_b[gi];
    end else begin : g_mid
      assign kept_valid[gi] = shift_in ? valid_q[gi+1] : valid_q[gi];
      assign kept_uop[gi]   = shift_in ? uop_q[gi+1]   : uop_q[gi];
      assign kept_ra[gi]    = shift_in ? (rdy_a_q[gi+1] | hit_a[gi+1])
                                       : (rdy_a_q[gi]   | hit_a[gi]);
      assign kept_rb[gi]    = shift_in ? (rdy_b_q[gi+1] | hit_b[gi+1])
                                       : (rdy_b_q[gi]   | hit_b[gi]);
    end
  end

  // Next queue contents: collapsed view plus the new dispatch; flush wipes all.
  always_comb begin
    valid_d = kept_valid;
    rdy_a_d = kept_ra;
    rdy_b_d = kept_rb;
    for (int i = 0; i < RS_DEPTH; i++) begin
      uop_d[i] = kept_uop[i];
      if (accept && (wr_idx == CW'(i))) begin
        valid_d[i] = 1'b1;
        uop_d[i]   = i_uop;
        rdy_a_d[i] = disp_rdy_a;
        rdy_b_d[i] = disp_rdy_b;
      end
    end
    if (i_flush) valid_d = '0;
  end

  // Next issue register and occupancy; a stalled, occupied output holds.
  always_comb begin
    out_valid_d = out_valid_q;
    out_uop_d   = out_uop_q;
    count_d     = count_q;
    if (i_flush) begin
      out_valid_d = 1'b0;
      count_d     = '0;
    end else begin
      if (can_sel) begin
        out_valid_d = issue;
        if (issue) out_uop_d = uop_q[sel_idx];
      end
      count_d = count_q + CW'(accept) - CW'(issue);
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      valid_q     <= '0;
      rdy_a_q     <= '0;
      rdy_b_q     <= '0;
      out_valid_q <= 1'b0;
      out_uop_q   <= '0;
      count_q     <= '0;
      for (int i = 0; i < RS_DEPTH; i++) uop_q[i] <= '0;
    end else begin
      valid_q     <= valid_d;
      rdy_a_q     <= rdy_a_d;
      rdy_b_q     <= rdy_b_d;
      out_valid_q <= out_valid_d;
      out_uop_q   <= out_uop_d;
      count_q     <= count_d;
      for (int i = 0; i < RS_DEPTH; i++) uop_q[i] <= uop_d[i];
    end
  end

  assign o_uop_p = out_valid_q;
  assign o_uop   = out_uop_q;
  assign o_count = count_q;

endmodule

// File: tb/tb_alu_reservation_station.sv
// Self-checking bench for alu_reservation_station: directed scenarios with
// literal expectations, then randomized traffic against a queue-based model.
module tb_alu_reservation_station;
  import alu_rs_pkg::*;

  localparam int DEPTH = 8;
  localparam int PW    = 6;
  localparam int CW    = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                uop_p;
  micro_op_t           uop;
  logic [1:0]          opr_rdy;
  logic                stall;
  logic [1:0]          wb_we;
  logic [1:0][PW-1:0]  wb_trgt;
  logic                out_p;
  micro_op_t           out_uop;
  logic                alu_stall;
  logic                flush;
  logic [CW-1:0]       count;

  always #5 clk = ~clk;

  alu_reservation_station #(.NUM_PHYSICAL_REGS(64), .RS_DEPTH(DEPTH)) dut (
    .i_clk      (clk),
    .i_rst      (rst_n),
    .i_uop_p    (uop_p),
    .i_uop      (uop),
    .i_opr_rdy  (opr_rdy),
    .o_stall    (stall),
    .i_wb_we    (wb_we),
    .i_wb_trgt  (wb_trgt),
    .o_uop_p    (out_p),
    .o_uop      (out_uop),
    .i_alu_stall(alu_stall),
    .i_flush    (flush),
    .o_count    (count)
  );

  // Behavioural model: age-ordered list of waiting uops plus the issue slot.
  typedef struct {
    micro_op_t u;
    bit        ra;
    bit        rb;
  } ent_t;

  ent_t      mq[$];
  bit        m_valid;
  micro_op_t m_uop;
  bit        m_issued;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit mhit(input logic [5:0] tag);
    return (wb_we[0] && wb_trgt[0] == tag) || (wb_we[1] && wb_trgt[1] == tag);
  endfunction

  function automatic bit m_ready(input ent_t e);
`ifdef RS_WAKEUP_BYPASS_EN
    return (e.ra || mhit(e.u.operand_a)) && (e.rb || mhit(e.u.operand_b));
`else
    return e.ra && e.rb;
`endif
  endfunction

  function automatic micro_op_t mk(input logic [5:0] a, input logic [5:0] b,
                                   input logic [15:0] imm);
    micro_op_t m;
    m           = '0;
    m.operand_a = a;
    m.operand_b = b;
    m.imm       = imm;
    m.opcode    = imm[3:0];
    m.dest      = imm[9:4];
    return m;
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    bit   acc;
    bit   can_sel;
    int   sel;
    ent_t e;
    m_issued = 1'b0;
    if (flush) begin
      mq.delete();
      m_valid = 1'b0;
      return;
    end
    acc     = uop_p && (mq.size() < DEPTH);
    can_sel = !m_valid || !alu_stall;
    sel     = -1;
    foreach (mq[i]) if (sel < 0 && m_ready(mq[i])) sel = i;
    if (can_sel) begin
      if (sel >= 0) begin
        m_uop    = mq[sel].u;
        m_valid  = 1'b1;
        m_issued = 1'b1;
        mq.delete(sel);
      end else begin
        m_valid = 1'b0;
      end
    end
    foreach (mq[i]) begin
      mq[i].ra = mq[i].ra | mhit(mq[i].u.operand_a);
      mq[i].rb = mq[i].rb | mhit(mq[i].u.operand_b);
    end
    if (acc) begin
      e.u  = uop;
      e.ra = opr_rdy[0] | mhit(uop.operand_a);
      e.rb = opr_rdy[1] | mhit(uop.operand_b);
      mq.push_back(e);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_valid = 1'b0;
    m_uop   = '0;
  endtask

  task automatic compare();
    chk("uop_p", 64'(out_p), 64'(m_valid));
    chk("count", 64'(count), 64'(mq.size()));
    chk("stall", 64'(stall), 64'(mq.size() == DEPTH));
    chk("uop",   64'(out_uop), 64'(m_uop));
  endtask

  task automatic cycle(input bit p, input micro_op_t u, input logic [1:0] rdy,
                       input logic [1:0] we, input logic [5:0] t0, input logic [5:0] t1,
                       input bit st, input bit fl);
    @(negedge clk);
    uop_p      = p;
    uop        = u;
    opr_rdy    = rdy;
    wb_we      = we;
    wb_trgt[0] = t0;
    wb_trgt[1] = t1;
    alu_stall  = st;
    flush      = fl;
    model_step();
    @(posedge clk);
    #1;
    compare();
    if (m_issued)
      $display("[TB] t=%0t issue imm=%04h opa=%0d opb=%0d count=%0d",
               $time, m_uop.imm, m_uop.operand_a, m_uop.operand_b, mq.size());
  endtask

  task automatic idle(input bit st);
    cycle(1'b0, '0, 2'b00, 2'b00, 6'd0, 6'd0, st, 1'b0);
  endtask

  initial begin
    rst_n     = 1'b0;
    uop_p     = 1'b0;
    uop       = '0;
    opr_rdy   = 2'b00;
    wb_we     = 2'b00;
    wb_trgt   = '0;
    alu_stall = 1'b0;
    flush     = 1'b0;
    model_reset();
    m_issued  = 1'b0;

    // Reset state
    #1;
    chk("rst_uop_p", 64'(out_p), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_uop",   64'(out_uop), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Ready uop: captured at edge 1, issued at edge 2
    cycle(1'b1, mk(6'd1, 6'd2, 16'h0033), 2'b11, 2'b00, 6'd0, 6'd0, 1'b0, 1'b0);
    chk("lat_e1_p",   64'(out_p), 64'd0);
    chk("lat_e1_cnt", 64'(count), 64'd1);
    idle(1'b0);
    chk("lat_e2_p",   64'(out_p), 64'd1);
    chk("lat_e2_cnt", 64'(count), 64'd0);
    chk("lat_e2_imm", 64'(out_uop.imm), 64'h0033);
    idle(1'b0);
    chk("lat_e3_p",   64'(out_p), 64'd0);

    // Wakeup of operand_a = 5 through write port 0
    cycle(1'b1, mk(6'd5, 6'd7, 16'h0034), 2'b10, 2'b00, 6'd0, 6'd0, 1'b0, 1'b0);
    idle(1'b0);
    chk("wk_wait_p", 64'(out_p), 64'd0);
    cycle(1'b0, '0, 2'b00, 2'b01, 6'd5, 6'd0, 1'b0, 1'b0);
`ifdef RS_WAKEUP_BYPASS_EN
    chk("wk_edge_p",   64'(out_p), 64'd1);
    chk("wk_edge_imm", 64'(out_uop.imm), 64'h0034);
    idle(1'b0);
    chk("wk_next_p",   64'(out_p), 64'd0);
`else
    chk("wk_edge_p",   64'(out_p), 64'd0);
    chk("wk_edge_cnt", 64'(count), 64'd1);
    idle(1'b0);
    chk("wk_next_p",   64'(out_p), 64'd1);
    chk("wk_next_imm", 64'(out_uop.imm), 64'h0034);
`endif
    idle(1'b0);

    // Fill under ALU stall, then drain in order
    for (int k = 0; k < 9; k++)
      cycle(1'b1, mk(6'd1, 6'd2, 16'(100 + k)), 2'b11, 2'b00, 6'd0, 6'd0, 1'b1, 1'b0);
    chk("full_cnt",   64'(count), 64'd8);
    chk("full_stall", 64'(stall), 64'd1);
    chk("full_imm",   64'(out_uop.imm), 64'd100);
    for (int j = 1; j <= 8; j++) begin
      idle(1'b0);
      chk("drain_imm", 64'(out_uop.imm), 64'(100 + j));
      chk("drain_p",   64'(out_p), 64'd1);
    end
    idle(1'b0);
    chk("drain_end_p", 64'(out_p), 64'd0);

    // Middle entry ready: it issues first, neighbours collapse
    cycle(1'b1, mk(6'd10, 6'd1, 16'd200), 2'b10, 2'b00, 6'd0, 6'd0, 1'b0, 1'b0);
    cycle(1'b1, mk(6'd1,  6'd1, 16'd201), 2'b11, 2'b00, 6'd0, 6'd0, 1'b0, 1'b0);
    cycle(1'b1, mk(6'd11, 6'd1, 16'd202), 2'b10, 2'b00, 6'd0, 6'd0, 1'b0, 1'b0);
    chk("ooo_imm", 64'(out_uop.imm), 64'd201);
    chk("ooo_cnt", 64'(count), 64'd2);
    idle(1'b0);
    cycle(1'b0, '0, 2'b00, 2'b01, 6'd11, 6'd0, 1'b0, 1'b0);
    idle(1'b0);
    chk("ooo_c_imm", 64'(out_uop.imm), 64'd202);
    chk("ooo_c_cnt", 64'(count), 64'd1);
    cycle(1'b0, '0, 2'b00, 2'b10, 6'd0, 6'd10, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);

    // Flush with 5 held entries and a busy output; dispatch on that edge dropped
    for (int k = 0; k < 6; k++)
      cycle(1'b1, mk(6'd2, 6'd3, 16'(300 + k)), 2'b11, 2'b00, 6'd0, 6'd0, 1'b1, 1'b0);
    chk("pre_fl_cnt", 64'(count), 64'd5);
    chk("pre_fl_p",   64'(out_p), 64'd1);
    cycle(1'b1, mk(6'd3, 6'd3, 16'h0370), 2'b11, 2'b00, 6'd0, 6'd0, 1'b1, 1'b1);
    chk("fl_cnt", 64'(count), 64'd0);
    chk("fl_p",   64'(out_p), 64'd0);
    idle(1'b0);
    chk("post_fl_cnt", 64'(count), 64'd0);
    chk("post_fl_p",   64'(out_p), 64'd0);

    // Asynchronous reset between edges with 3 held entries
    for (int k = 0; k < 4; k++)
      cycle(1'b1, mk(6'd4, 6'd4, 16'(400 + k)), 2'b11, 2'b00, 6'd0, 6'd0, 1'b1, 1'b0);
    chk("pre_rst_cnt", 64'(count), 64'd3);
    chk("pre_rst_p",   64'(out_p), 64'd1);
    @(negedge clk);
    uop_p = 1'b0;
    wb_we = 2'b00;
    flush = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_p",     64'(out_p), 64'd0);
    chk("arst_cnt",   64'(count), 64'd0);
    chk("arst_stall", 64'(stall), 64'd0);
    chk("arst_uop",   64'(out_uop), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle(1'b0);

    // Randomized traffic with alternating light/heavy ALU back-pressure
    for (int c = 0; c < 3000; c++) begin
      micro_op_t ru;
      int        st_pct;
      ru        = mk(6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)), 16'($urandom));
      ru.opcode = 4'($urandom);
      st_pct    = ((c / 400) % 2 == 1) ? 75 : 25;
      cycle($urandom_range(0, 99) < 60, ru, 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), 6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)),
            $urandom_range(0, 99) < st_pct, $urandom_range(0, 199) < 3);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_reservation_station.md
ALU_RESERVATION_STATION -- requirements
Module: alu_reservation_station

Interface
REQ-001 SHALL have parameter NUM_PHYSICAL_REGS, default 64, physical register count; tag width PW = $clog2(NUM_PHYSICAL_REGS).
REQ-002 SHALL have parameter RS_DEPTH, default 8, entry count, power of two, >= 2.
REQ-003 SHALL have port i_clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port i_rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port i_uop_p  input  1  dispatch uop present.
REQ-006 SHALL have port i_uop  input  micro_op_t  dispatched ALU uop.
REQ-007 SHALL have port i_opr_rdy  input  2  operand_a/operand_b ready at dispatch, bit 0 = a.
REQ-008 SHALL have port o_stall  output  1  station full; dispatcher must not present a uop.
REQ-009 SHALL have port i_wb_we  input  2  PRF write-port enables, wakeup broadcast.
REQ-010 SHALL have port i_wb_trgt  input  2xPW  PRF write-port target tags.
REQ-011 SHALL have port o_uop_p  output  1  issue valid to ALU.
REQ-012 SHALL have port o_uop  output  micro_op_t  issued uop.
REQ-013 SHALL have port i_alu_stall  input  1  ALU not accepting.
REQ-014 SHALL have port i_flush  input  1  discard all held uops.
REQ-015 SHALL have port o_count  output  $clog2(RS_DEPTH)+1  valid entry count.

Function
REQ-016 SHALL store entries in a collapsing queue; index 0 is oldest; on removal, younger entries shift down one slot in the same edge.
REQ-017 SHALL hold, per entry: valid, micro_op_t, rdy_a, rdy_b.
REQ-018 SHALL drive o_stall = 1 combinationally iff o_count == RS_DEPTH; occupancy before that edge's issue, so a full station stalls even when an issue happens in the same cycle.
REQ-019 SHALL accept a dispatch when i_uop_p && !o_stall, writing it at the first free slot after any same-edge shift, with rdy bits = i_opr_rdy.
REQ-020 SHALL set an entry's rdy_a (rdy_b) at an edge where any i_wb_we[k] is 1 and i_wb_trgt[k] equals operand_a (operand_b); this applies to held entries and to the uop being dispatched on that edge.
REQ-021 SHALL treat an entry as eligible when valid && rdy_a && rdy_b, using registered ready bits only (see REQ-032).
REQ-022 SHALL select, at each edge, the lowest-index eligible entry when the output register is empty or being accepted (o_uop_p == 0 || !i_alu_stall).
REQ-023 SHALL load the selected entry into the o_uop/o_uop_p register and remove it from the queue on the same edge.
REQ-024 SHALL clear o_uop_p when the output is accepted and nothing is eligible.
REQ-025 SHALL hold o_uop and o_uop_p unchanged while o_uop_p && i_alu_stall; no selection is made on that edge.
REQ-026 SHALL give a minimum latency of 2 edges from dispatch to o_uop_p with operands ready: captured at edge N, issued at edge N+1, visible after N+1.
REQ-027 SHALL sustain one issue per cycle when eligible entries exist and i_alu_stall = 0.
REQ-028 SHALL update o_count at each edge by +accepted dispatch, -issue; simultaneous dispatch and issue leaves it unchanged.
REQ-029 SHALL, on i_flush = 1 at an edge, clear all valid bits, o_uop_p, and o_count; it ignores dispatch and wakeup on that edge; flush has priority over all other events.

Reset
REQ-030 SHALL, while i_rst == 0, asynchronously force all entry valid bits to 0, o_uop_p = 0, o_count = 0, and o_uop to all zeros; o_stall then reads 0.
REQ-031 SHALL resume normal operation on the first rising edge after i_rst deasserts; a reset mid-operation discards all held and issuing uops.

Configuration
REQ-032 SHALL support macro RS_WAKEUP_BYPASS_EN:
- When defined: eligibility also counts wakeup matches on the current edge (rdy | match), so an entry woken at edge N may issue at edge N.
- When undefined: the woken entry first becomes eligible at edge N+1.

Verification
REQ-033 SHALL pass: uop dispatched with i_opr_rdy = 2'b11 at edge 1, i_alu_stall = 0 -> o_uop_p = 1 after edge 2, o_count back to 0.
REQ-034 SHALL pass: uop with operand_a = 5, i_opr_rdy = 2'b10; i_wb_we = 2'b01, i_wb_trgt[0] = 5 at edge 4 -> issue at edge 4 with RS_WAKEUP_BYPASS_EN, edge 5 without.
REQ-035 SHALL pass: 8 ready uops dispatched back-to-back with i_alu_stall = 1 -> o_stall = 1 once o_count = 8; on release, issue in dispatch order, one per cycle.
REQ-036 SHALL pass: entries 0 and 2 not ready, entry 1 ready -> entry 1 issues first; entries 0 and 2 collapse to indices 0 and 1.
REQ-037 SHALL pass: i_flush with 5 entries and o_uop_p = 1 -> o_count = 0, o_uop_p = 0 next cycle; a dispatch on the flush edge is dropped.
REQ-038 SHALL pass: i_rst driven low between clock edges with 3 entries -> o_uop_p and o_count go to 0 immediately, without waiting for a clock edge.
